// File: rtl/rsa_operand_loader.sv
// rtl/rsa_operand_loader.sv - byte-serial RSA operand assembler and validator
// Optional partial-frame idle timeout: define RSA_LOADER_TIMEOUT_EN
module rsa_operand_loader #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_message,
  output logic [31:0] out_e,
  output logic [31:0] out_n,
  output logic        err,
  output logic [2:0]  err_code
);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_CHECK,
    S_DECIDE,
    S_OFFER,
    S_ERR
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] msg_q;
  logic [31:0] e_q;
  logic [31:0] n_q;
  logic [2:0]  chk_code;
  logic        accept;
  logic        expire;
  logic [3:0]  byte_idx;

  assign in_ready = (state == S_COLLECT);
  assign accept   = in_valid && in_ready;

`ifdef RSA_LOADER_TIMEOUT_EN
  logic [15:0] idle;

  assign expire = in_ready && (cnt != 4'd0) && (idle == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle <= '0;
    end else if (!in_ready || accept || (cnt == 4'd0) || expire) begin
      idle <= '0;
    end else begin
      idle <= idle + 16'd1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  // A byte landing on the expiry cycle starts a fresh frame.
  assign byte_idx = expire ? 4'd0 : cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_COLLECT;
      cnt         <= '0;
      msg_q       <= '0;
      e_q         <= '0;
      n_q         <= '0;
      chk_code    <= '0;
      out_valid   <= 1'b0;
      out_message <= '0;
      out_e       <= '0;
      out_n       <= '0;
      err         <= 1'b0;
      err_code    <= '0;
    end else begin
      err      <= 1'b0;
      err_code <= '0;
      case (state)
        S_COLLECT: begin
          if (expire) begin
            err      <= 1'b1;
            err_code <= 3'd4;
            cnt      <= '0;
          end
          if (accept) begin
            case (byte_idx[3:2])
              2'd0:    msg_q <= {msg_q[23:0], in_data};
              2'd1:    e_q   <= {e_q[23:0], in_data};
              default: n_q   <= {n_q[23:0], in_data};
            endcase
            if (byte_idx == 4'd11) begin
              cnt   <= '0;
              state <= S_CHECK;
            end else begin
              cnt <= byte_idx + 4'd1;
            end
          end
        end
        S_CHECK: begin
          if (n_q < 32'd2)        chk_code <= 3'd1;
          else if (msg_q >= n_q)  chk_code <= 3'd2;
          else if (e_q == 32'd0)  chk_code <= 3'd3;
          else                    chk_code <= 3'd0;
          state <= S_DECIDE;
        end
        S_DECIDE: begin
          if (chk_code == 3'd0) begin
            out_message <= msg_q;
            out_e       <= e_q;
            out_n       <= n_q;
            out_valid   <= 1'b1;
            state       <= S_OFFER;
          end else begin
            err      <= 1'b1;
            err_code <= chk_code;
            state    <= S_ERR;
          end
        end
        S_OFFER: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_COLLECT;
          end
        end
        S_ERR: begin
          // Hold off input for the error pulse cycle.
          state <= S_COLLECT;
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_operand_loader.sv
// tb/tb_rsa_operand_loader.sv - randomized and directed bench for rsa_operand_loader
// Timeout scenario is exercised only when RSA_LOADER_TIMEOUT_EN is defined.
module tb_rsa_operand_loader;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_message;
  logic [31:0] out_e;
  logic [31:0] out_n;
  logic        err;
  logic [2:0]  err_code;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int or_mode = 0;
  int last_acc = 0;

  rsa_operand_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_message(out_message), .out_e(out_e), .out_n(out_n),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always begin
    @(posedge clk);
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: bytes accepted so far, plus the outcome of the
  // last complete frame and the cycle its result must appear.
  logic [7:0]  bytes[$];
  logic        busy = 1'b0;
  int          due = 0;
  int          to_due = -1;
  int          idle_m = 0;
  logic [2:0]  m_code;
  logic [31:0] m_msg, m_e, m_n;
  logic        exp_v, exp_e;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_out_message", out_message, 0);
      chk("rst_out_e", out_e, 0);
      chk("rst_out_n", out_n, 0);
      busy = 1'b0;
      bytes.delete();
      to_due = -1;
      idle_m = 0;
    end else begin
      exp_v = busy && (m_code == 3'd0) && (cyc >= due);
      exp_e = (busy && (m_code != 3'd0) && (cyc == due)) || (cyc == to_due);
      chk("in_ready", in_ready, !busy);
      chk("out_valid", out_valid, exp_v);
      chk("err", err, exp_e);
      if (exp_e) chk("err_code", err_code, busy ? m_code : 3'd4);
      if (exp_v) begin
        chk("out_message", out_message, m_msg);
        chk("out_e", out_e, m_e);
        chk("out_n", out_n, m_n);
      end
      if (busy) begin
        if (m_code == 3'd0 && cyc >= due && out_ready) busy = 1'b0;
        else if (m_code != 3'd0 && cyc == due) busy = 1'b0;
      end else begin
`ifdef RSA_LOADER_TIMEOUT_EN
        if (bytes.size() != 0 && idle_m == TO) begin
          bytes.delete();
          to_due = cyc + 1;
          idle_m = 0;
        end else if (bytes.size() != 0 && !in_valid) begin
          idle_m = idle_m + 1;
        end
`endif
        if (in_valid) begin
          bytes.push_back(in_data);
          idle_m = 0;
          if (bytes.size() == 12) begin
            m_msg = {bytes[0], bytes[1], bytes[2], bytes[3]};
            m_e   = {bytes[4], bytes[5], bytes[6], bytes[7]};
            m_n   = {bytes[8], bytes[9], bytes[10], bytes[11]};
            if (m_n < 2)             m_code = 3'd1;
            else if (m_msg >= m_n)   m_code = 3'd2;
            else if (m_e == 0)       m_code = 3'd3;
            else                     m_code = 3'd0;
            busy = 1'b1;
            due = cyc + 3;
            bytes.delete();
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    acc = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL byte_accept_timeout actual=0 required=1 at cycle %0d", cyc);
    end
    in_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic send_frame(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n,
                            input int maxgap, input int nbytes);
    logic [95:0] f;
    f = {m, e, n};
    for (int i = 0; i < nbytes; i++) send_byte(f[95-8*i -: 8], int'($urandom_range(0, maxgap)));
  endtask

  task automatic wait_event(output int lat);
    logic ok;
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid || err) begin ok = 1'b1; break; end
      @(posedge clk);
      #1;
      lat = lat + 1;
    end
    if (!ok) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL result_timeout actual=0 required=1 at cycle %0d", cyc);
    end
  endtask

  task automatic run_valid();
    int lat;
    or_mode = 0;
    send_frame(32'h41, 32'h10001, 32'hC5D7, 0, 12);
    wait_event(lat);
    chk("lit_latency", lat, 2);
    chk("lit_out_valid", out_valid, 1);
    chk("lit_message", out_message, 32'h41);
    chk("lit_e", out_e, 32'h10001);
    chk("lit_n", out_n, 32'hC5D7);
    @(posedge clk); #1;
    chk("lit_in_ready_after", in_ready, 1);
    chk("lit_out_valid_after", out_valid, 0);
  endtask

  task automatic run_error(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n,
                           input logic [2:0] code);
    int lat;
    send_frame(m, e, n, 0, 12);
    wait_event(lat);
    chk("lit_err", err, 1);
    chk("lit_err_code", err_code, code);
    chk("lit_err_no_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("lit_err_single", err, 0);
    chk("lit_err_in_ready", in_ready, 1);
    run_valid();
  endtask

  initial begin
    int lat;
    logic [31:0] m, e, n;
    #12;
    @(posedge clk); #1;
    chk("lit_reset_in_ready", in_ready, 1);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("lit_idle_out_valid", out_valid, 0);

    run_valid();

    or_mode = 2;
    send_frame(32'h41, 32'h10001, 32'hC5D7, 0, 12);
    wait_event(lat);
    in_valid = 1'b1;
    in_data = 8'hAA;
    repeat (20) begin @(posedge clk); #1; end
    chk("lit_bp_valid", out_valid, 1);
    chk("lit_bp_in_ready", in_ready, 0);
    chk("lit_bp_n", out_n, 32'hC5D7);
    in_valid = 1'b0;
    or_mode = 0;
    for (int i = 0; i < 10 && out_valid; i++) begin @(posedge clk); #1; end
    chk("lit_bp_released", out_valid, 0);
    chk("lit_bp_in_ready_back", in_ready, 1);

    run_error(32'h5, 32'h10001, 32'h1, 3'd1);
    run_error(32'hC5D7, 32'h10001, 32'hC5D7, 3'd2);
    run_error(32'h41, 32'h0, 32'hC5D7, 3'd3);
    run_error(32'h5, 32'h0, 32'h1, 3'd1);

    send_frame(32'h41, 32'h10001, 32'hC5D7, 0, 8);
    #2 reset_n = 1'b0;
    @(posedge clk); #1;
    chk("lit_midframe_rst_in_ready", in_ready, 1);
    chk("lit_midframe_rst_msg", out_message, 0);
    reset_n = 1'b1;
    run_valid();

    or_mode = 2;
    send_frame(32'h41, 32'h10001, 32'hC5D7, 0, 12);
    wait_event(lat);
    #2 reset_n = 1'b0;
    @(posedge clk); #1;
    chk("lit_offer_rst_valid", out_valid, 0);
    chk("lit_offer_rst_n", out_n, 0);
    reset_n = 1'b1;
    run_valid();

`ifdef RSA_LOADER_TIMEOUT_EN
    send_frame(32'h12345678, 32'h10001, 32'hC5D7, 0, 5);
    wait_event(lat);
    chk("lit_to_latency", lat, TO + 1);
    chk("lit_to_err_code", err_code, 4);
    chk("lit_to_in_ready", in_ready, 1);
    run_valid();
`endif

    or_mode = 1;
    for (int k = 0; k < 40; k++) begin
      n = $urandom | 32'h2;
      m = $urandom % n;
      e = $urandom;
      case ($urandom_range(0, 5))
        0: n = $urandom_range(0, 1);
        1: m = n + $urandom_range(0, 3);
        2: e = 32'h0;
        3: m = n - 1;
        default: ;
      endcase
      send_frame(m, e, n, 2, 12);
    end
    or_mode = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (in_ready && !out_valid && !err) break;
    end
    chk("drain_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
